// File: rtl/bin2bcd_param.sv
`default_nettype none
// bin2bcd_param: sequential shift-add-3 binary-to-BCD converter, one bit per clock (rev 1.0).
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign port added.
module bin2bcd_param #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN2BCD_SIGNED_EN
  output logic                  overflow,
  output logic                  sign
`else
  output logic                  overflow
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BIN_W-1:0]    shreg;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] adj;
  logic [BIN_W-1:0]    load_val;

`ifdef BIN2BCD_SIGNED_EN
  // BIN_W-bit negation makes the most negative value map to its exact magnitude.
  assign load_val = bin[BIN_W-1] ? (-bin) : bin;
`else
  assign load_val = bin;
`endif

  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] > 4'd4) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        state_next = start ? OP : IDLE;
      end
      OP:   state_next = (cnt == CNT_W'(1)) ? DONE : OP;
      DONE: begin
        done_tick  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= load_val;
            bcd      <= '0;
            overflow <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
            sign     <= bin[BIN_W-1];
`endif
          end
        end
        OP: begin
          // The bit shifted out of the top adjusted digit is a lost multiple of 10^DIGITS.
          {bcd, shreg} <= {adj[4*DIGITS-2:0], shreg, 1'b0};
          overflow     <= overflow | adj[4*DIGITS-1];
          cnt          <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
